// File: rtl/jk_cmd_sequencer.sv
// rtl/jk_cmd_sequencer.sv - queued JK drive sequencer with expected-Q check
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             j,
  output logic             k,
  input  logic             q_in,
  output logic             busy,
  output logic             chk_pulse,
  output logic             err,
  output logic [7:0]       err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, EXEC, CHECK} state_t;

  state_t           state;
  logic [LEN_W+1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [1:0]       op;
  logic [LEN_W-1:0] rem;
  logic             exp_q;
  logic             push;
  logic             pop;
  logic [1:0]       head_op;
  logic [LEN_W-1:0] head_len;

  assign cmd_ready = (count != CNT_FULL);
  assign push      = cmd_valid && cmd_ready && !reset;
  // Pops only from IDLE or CHECK, so a freshly pushed entry is never seen the same edge.
  assign pop       = !reset && (count != '0) && (state == IDLE || state == CHECK);
  assign {head_op, head_len} = mem[rd_ptr];
  assign busy      = (state != IDLE) || (count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_op, cmd_len};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      j         <= 1'b0;
      k         <= 1'b0;
      exp_q     <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      op        <= 2'b00;
      rem       <= '0;
      chk_pulse <= 1'b0;
      err       <= 1'b0;
      err_count <= 8'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      case (state)
        IDLE: begin
          if (pop) begin
            op     <= head_op;
            rem    <= head_len;
            {j, k} <= head_op;
            state  <= EXEC;
          end
        end
        EXEC: begin
          // Mirrors the downstream flip-flop, which sees this same {j,k} at this edge.
          case (op)
            2'b01:   exp_q <= 1'b0;
            2'b10:   exp_q <= 1'b1;
            2'b11:   exp_q <= ~exp_q;
            default: exp_q <= exp_q;
          endcase
          if (rem == '0) begin
            {j, k}    <= 2'b00;
            chk_pulse <= 1'b1;
            state     <= CHECK;
          end else begin
            rem <= rem - 1'b1;
          end
        end
        CHECK: begin
          chk_pulse <= 1'b0;
          if (q_in != exp_q) begin
            err <= 1'b1;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          end
          if (pop) begin
            op     <= head_op;
            rem    <= head_len;
            {j, k} <= head_op;
            state  <= EXEC;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          {j, k}    <= 2'b00;
          chk_pulse <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// tb/tb_jk_cmd_sequencer.sv - directed bench for jk_cmd_sequencer with a JK flip-flop load
module tb_jk_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [LEN_W-1:0] cmd_len;
  logic             j;
  logic             k;
  logic             q_in;
  logic             busy;
  logic             chk_pulse;
  logic             err;
  logic [7:0]       err_count;

  logic       q_ff;
  logic       force_en;
  logic       force_val;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         chk_cnt = 0;
  int         last_stall = 0;
  logic [7:0] cur_len = 8'd0;
  logic [1:0] cur_op = 2'b00;
  logic [9:0] run_log[$];
  logic [9:0] exp_runs[$];

  always #5 clk = ~clk;

  jk_cmd_sequencer #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .j(j), .k(k), .q_in(q_in),
    .busy(busy), .chk_pulse(chk_pulse), .err(err), .err_count(err_count)
  );

  // Downstream JK flip-flop sharing clk and reset.
  always @(posedge clk) begin
    if (reset) q_ff <= 1'b0;
    else case ({j, k})
      2'b01:   q_ff <= 1'b0;
      2'b10:   q_ff <= 1'b1;
      2'b11:   q_ff <= ~q_ff;
      default: q_ff <= q_ff;
    endcase
  end
  assign q_in = force_en ? force_val : q_ff;

  // Records each command as {op, cycles driven}, closed by its check strobe.
  always @(negedge clk) begin
    if (reset) begin
      cur_len <= 8'd0;
    end else if (chk_pulse) begin
      run_log.push_back({cur_op, cur_len});
      cur_len <= 8'd0;
      chk_cnt <= chk_cnt + 1;
    end else if ({j, k} != 2'b00) begin
      cur_op  <= {j, k};
      cur_len <= cur_len + 8'd1;
    end
  end

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    run_log.delete();
    exp_runs.delete();
  endtask

  task automatic push_cmd(input logic [1:0] op, input logic [LEN_W-1:0] len);
    last_stall = 0;
    while (!cmd_ready && last_stall < 200) begin
      step(1);
      last_stall++;
    end
    expect_eq("push_ready", cmd_ready, 1);
    cmd_op    = op;
    cmd_len   = len;
    cmd_valid = 1'b1;
    step(1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 3000) begin
      step(1);
      t++;
    end
    expect_eq("idle_reached", busy, 0);
    step(1);
  endtask

  task automatic wait_chk();
    int t = 0;
    while (!chk_pulse && t < 100) begin
      step(1);
      t++;
    end
    expect_eq("chk_seen", chk_pulse, 1);
  endtask

  task automatic check_runs(input string tag);
    expect_eq({tag, "_nruns"}, run_log.size(), exp_runs.size());
    for (int i = 0; i < exp_runs.size(); i++)
      if (i < run_log.size()) expect_eq($sformatf("%s_run%0d", tag, i), run_log[i], exp_runs[i]);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b10; cmd_len = '0;
    force_en = 1'b0; force_val = 1'b0;

    // Reset state, with cmd_valid held high during reset.
    step(2);
    reset = 1'b0; cmd_valid = 1'b0;
    expect_eq("rst_jk", {j, k}, 2'b00);
    expect_eq("rst_ready", cmd_ready, 1);
    expect_eq("rst_busy", busy, 0);
    expect_eq("rst_chk", chk_pulse, 0);
    expect_eq("rst_err", err, 0);
    expect_eq("rst_errcnt", err_count, 0);
    step(3);
    expect_eq("rst_valid_ignored", busy, 0);
    run_log.delete();

    // Set then check, cycle by cycle.
    push_cmd(2'b10, 4'd2);
    expect_eq("set_nobypass_jk", {j, k}, 2'b00);
    expect_eq("set_busy", busy, 1);
    step(1); expect_eq("set_e1", {j, k}, 2'b10);
    step(1); expect_eq("set_e2", {j, k}, 2'b10);
    step(1); expect_eq("set_e3", {j, k}, 2'b10);
    expect_eq("set_e3_chk", chk_pulse, 0);
    step(1); expect_eq("set_chk_jk", {j, k}, 2'b00);
    expect_eq("set_chk_pulse", chk_pulse, 1);
    expect_eq("set_chk_q", q_in, 1);
    step(1); expect_eq("set_after_chk", chk_pulse, 0);
    expect_eq("set_after_busy", busy, 0);
    expect_eq("set_after_err", err, 0);
    exp_runs.push_back({2'b10, 8'd3});
    check_runs("set");

    // Toggle parity from 0, plus longest length.
    do_reset();
    push_cmd(2'b11, 4'd2);
    wait_idle();
    expect_eq("tog3_q", q_in, 1);
    expect_eq("tog3_err", err, 0);
    push_cmd(2'b11, 4'd1);
    wait_chk();
    expect_eq("tog2_chk_q", q_in, 1);
    wait_idle();
    expect_eq("tog2_err", err, 0);
    push_cmd(2'b01, 4'd15);
    wait_idle();
    expect_eq("clr16_q", q_in, 0);
    expect_eq("clr16_err", err, 0);
    exp_runs.push_back({2'b11, 8'd3});
    exp_runs.push_back({2'b11, 8'd2});
    exp_runs.push_back({2'b01, 8'd16});
    check_runs("tog");

    // Backpressure: fill the FIFO while a long command executes.
    do_reset();
    push_cmd(2'b10, 4'd7);
    push_cmd(2'b01, 4'd0);
    push_cmd(2'b10, 4'd1);
    push_cmd(2'b11, 4'd0);
    push_cmd(2'b01, 4'd2);
    expect_eq("bp_full_ready", cmd_ready, 0);
    expect_eq("bp_full_busy", busy, 1);
    push_cmd(2'b10, 4'd0);
    expect_eq("bp_stalled", last_stall > 0, 1);
    wait_idle();
    expect_eq("bp_err", err, 0);
    exp_runs.push_back({2'b10, 8'd8});
    exp_runs.push_back({2'b01, 8'd1});
    exp_runs.push_back({2'b10, 8'd2});
    exp_runs.push_back({2'b11, 8'd1});
    exp_runs.push_back({2'b01, 8'd3});
    exp_runs.push_back({2'b10, 8'd1});
    check_runs("bp");

    // Push on the CHECK-to-EXEC pop edge with occupancy 2.
    do_reset();
    push_cmd(2'b10, 4'd3);
    push_cmd(2'b01, 4'd3);
    push_cmd(2'b10, 4'd3);
    wait_chk();
    push_cmd(2'b11, 4'd0);
    push_cmd(2'b01, 4'd0);
    expect_eq("pp_occ3_ready", cmd_ready, 1);
    push_cmd(2'b10, 4'd0);
    expect_eq("pp_occ4_ready", cmd_ready, 0);
    wait_idle();
    expect_eq("pp_err", err, 0);
    exp_runs.push_back({2'b10, 8'd4});
    exp_runs.push_back({2'b01, 8'd4});
    exp_runs.push_back({2'b10, 8'd4});
    exp_runs.push_back({2'b11, 8'd1});
    exp_runs.push_back({2'b01, 8'd1});
    exp_runs.push_back({2'b10, 8'd1});
    check_runs("pp");

    // Forced mismatches and saturation.
    do_reset();
    force_en = 1'b1; force_val = 1'b0;
    push_cmd(2'b10, 4'd0);
    wait_idle();
    expect_eq("mm1_err", err, 1);
    expect_eq("mm1_cnt", err_count, 1);
    for (int i = 0; i < 253; i++) push_cmd(2'b10, 4'd0);
    wait_idle();
    expect_eq("mm254_cnt", err_count, 254);
    push_cmd(2'b10, 4'd0);
    wait_idle();
    expect_eq("mm255_cnt", err_count, 255);
    for (int i = 0; i < 45; i++) push_cmd(2'b10, 4'd0);
    wait_idle();
    expect_eq("mm300_cnt", err_count, 255);
    force_en = 1'b0;
    push_cmd(2'b10, 4'd0);
    wait_idle();
    expect_eq("mm_sticky_err", err, 1);
    expect_eq("mm_sticky_cnt", err_count, 255);

    // Reset during the second EXEC cycle with two queued.
    do_reset();
    expect_eq("mr_err_cleared", err, 0);
    expect_eq("mr_cnt_cleared", err_count, 0);
    push_cmd(2'b11, 4'd5);
    push_cmd(2'b01, 4'd0);
    push_cmd(2'b10, 4'd0);
    expect_eq("mr_exec2_jk", {j, k}, 2'b11);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    expect_eq("mr_jk", {j, k}, 2'b00);
    expect_eq("mr_ready", cmd_ready, 1);
    expect_eq("mr_busy", busy, 0);
    expect_eq("mr_chk", chk_pulse, 0);
    begin
      int c0;
      c0 = chk_cnt;
      step(20);
      expect_eq("mr_no_check", chk_cnt, c0);
      expect_eq("mr_still_idle", busy, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
